// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg: state encoding and default width shared by the serializer files.
package piso_serializer_pkg;
   localparam int WIDTH_DEFAULT = 8;
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;
endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: loadable down-counter with enable that saturates at zero.
module piso_bit_counter #(
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          en,
   output logic [CW-1:0] cnt,
   output logic          zero
);
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      cnt_d = load ? load_val : (en && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
      cnt = cnt_q;
      zero = (cnt_q == '0);
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter, MSB first, with ready/valid load side
// and back-to-back reload on the last bit tick.
module piso_serializer
   import piso_serializer_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   input  logic             shift_en,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_first,
   output logic             ser_last
);
   localparam int CW = $clog2(WIDTH);
   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CW-1:0]    cnt;
   logic             cnt_zero, busy, tick, accept;
   piso_bit_counter #(.CW(CW)) u_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (accept),
      .load_val (CW'(WIDTH - 1)),
      .en       (tick),
      .cnt      (cnt),
      .zero     (cnt_zero)
   );
   // Ready on the last tick lets the next word follow with no gap bit.
   always_comb begin
      busy = (state_q == SHIFT);
      tick = busy && shift_en;
      load_ready = !busy || (cnt_zero && shift_en);
      accept = load_valid && load_ready;
      state_d = accept ? SHIFT : (tick && cnt_zero) ? IDLE : state_q;
      sr_d = accept ? load_data : !tick ? sr_q : cnt_zero ? '0 : {sr_q[WIDTH-2:0], 1'b0};
      ser_valid = busy;
      ser_out = busy && sr_q[WIDTH-1];
      ser_first = busy && (cnt == CW'(WIDTH - 1));
      ser_last = busy && cnt_zero;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q <= IDLE;
         sr_q <= '0;
      end else begin
         state_q <= state_d;
         sr_q <= sr_d;
      end
endmodule
